mmio_console_fifo: RTL and testbench



---
 rtl/mmio_console_fifo_if.sv | 24 ++
 rtl/mmio_console_fifo.sv | 95 +++++++++
 tb/tb_mmio_console_fifo.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mmio_console_fifo_if.sv
// Data-memory-port bus between processor/dmem/console and the MMIO console FIFO.
// master = surrounding system (processor, dmem, consumer); slave = the FIFO block.
interface mmio_console_fifo_if;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        dmem_wren;
    logic [31:0] q_proc;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        overflow;

    modport master (
        output address_dmem, data, wren, q_dmem, tx_ready,
        input  dmem_wren, q_proc, tx_data, tx_valid, overflow
    );

    modport slave (
        input  address_dmem, data, wren, q_dmem, tx_ready,
        output dmem_wren, q_proc, tx_data, tx_valid, overflow
    );
endinterface

// File: rtl/mmio_console_fifo.sv
// MMIO console output stage: stores to ADDR_TX feed a byte FIFO drained over valid/ready.
// Define MMIO_CONSOLE_STATUS_EN to enable the status register at ADDR_STAT and the sticky overflow flag.
module mmio_console_fifo #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [11:0] ADDR_TX   = 12'hFFF,
    parameter logic [11:0] ADDR_STAT = 12'hFFE
) (
    input logic                clock,
    input logic                reset,
    mmio_console_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          hit_tx, push, pop, push_ok, full, empty;

    assign hit_tx  = (bus.address_dmem == ADDR_TX);
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = bus.wren & hit_tx;
    assign pop     = ~empty & bus.tx_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still take the byte.
    assign push_ok = push & (~full | pop);

    assign bus.tx_valid = ~empty;
    assign bus.tx_data  = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.data[7:0];
    end

    logic [23:0] unused_data_hi;
    assign unused_data_hi = bus.data[31:8];

`ifdef MMIO_CONSOLE_STATUS_EN
    logic hit_stat, clr, ovf_q, ovf_d;

    assign hit_stat = (bus.address_dmem == ADDR_STAT);
    assign clr      = bus.wren & hit_stat & bus.data[0];

    // Set wins over clear so a drop on the clearing edge is not lost.
    always_comb begin
        ovf_d = ovf_q;
        if (clr)             ovf_d = 1'b0;
        if (push & ~push_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign bus.dmem_wren = bus.wren & ~hit_tx & ~hit_stat;
    assign bus.q_proc    = hit_stat ? {16'h0, 8'(count_q), 5'h0, ovf_q, full, empty}
                                    : bus.q_dmem;
    assign bus.overflow  = ovf_q;
`else
    logic unused_stat;
    assign unused_stat   = (bus.address_dmem == ADDR_STAT);

    assign bus.dmem_wren = bus.wren & ~hit_tx;
    assign bus.q_proc    = bus.q_dmem;
    assign bus.overflow  = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_console_fifo.sv
// Directed plus randomized bench for mmio_console_fifo against a queue-based reference model.
module tb_mmio_console_fifo;
    localparam int DEPTH = 8;
`ifdef MMIO_CONSOLE_STATUS_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mmio_console_fifo_if bus ();

    mmio_console_fifo #(.DEPTH(DEPTH), .ADDR_TX(12'hFFF), .ADDR_STAT(12'hFFE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] mq[$];
    bit movf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        return {16'h0, 8'(mq.size()), 5'h0, movf, (mq.size() == DEPTH), (mq.size() == 0)};
    endfunction

    // Compare all outputs against the model for the inputs currently on the bus.
    task automatic check_outputs(input string tag);
        logic is_stat;
        is_stat = STAT_EN && (bus.address_dmem == 12'hFFE);
        chk({tag, ".dmem_wren"}, 32'(bus.dmem_wren),
            32'(bus.wren && bus.address_dmem != 12'hFFF && !is_stat));
        chk({tag, ".q_proc"}, bus.q_proc, is_stat ? model_status() : bus.q_dmem);
        chk({tag, ".tx_valid"}, 32'(bus.tx_valid), 32'(mq.size() != 0));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(movf));
        if (mq.size() != 0) chk({tag, ".tx_data"}, 32'(bus.tx_data), 32'(mq[0]));
    endtask

    // One processor cycle: drive, check before the edge, update the model on the edge.
    task automatic cyc(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
        bit popm, pushm, fullm;
        bus.address_dmem = a;
        bus.data         = d;
        bus.wren         = w;
        bus.tx_ready     = r;
        bus.q_dmem       = $urandom;
        #1 check_outputs("cyc");
        popm  = (mq.size() != 0) && r;
        pushm = w && (a == 12'hFFF);
        fullm = (mq.size() == DEPTH);
        @(posedge clock);
        if (STAT_EN && w && a == 12'hFFE && d[0]) movf = 1'b0;
        if (popm) void'(mq.pop_front());
        if (pushm) begin
            if (!fullm || popm) mq.push_back(d[7:0]);
            else if (STAT_EN)   movf = 1'b1;
        end
        @(negedge clock);
    endtask

    // Read the status address without storing; literal expectation only when status exists.
    task automatic peek_stat(input string tag, input logic [31:0] exp_lit);
        bus.address_dmem = 12'hFFE;
        bus.wren         = 1'b0;
        bus.tx_ready     = 1'b0;
        bus.q_dmem       = $urandom;
        #1;
        if (STAT_EN) chk(tag, bus.q_proc, exp_lit);
        else         chk(tag, bus.q_proc, bus.q_dmem);
        @(negedge clock);
    endtask

    initial begin
        bus.address_dmem = 12'h000;
        bus.data         = 32'h0;
        bus.wren         = 1'b0;
        bus.tx_ready     = 1'b0;
        bus.q_dmem       = 32'h0;

        // Reset state
        #1;
        chk("rst.tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rst.overflow", 32'(bus.overflow), 32'h0);
        peek_stat("rst.status", 32'h0000_0001);
        @(negedge clock);
        reset = 1'b0;

        // Three pushes with the consumer stalled
        cyc(12'hFFF, 32'h0000_0141, 1'b1, 1'b0);
        cyc(12'hFFF, 32'h0000_0042, 1'b1, 1'b0);
        cyc(12'hFFF, 32'h0000_0043, 1'b1, 1'b0);
        chk("tp1.tx_data", 32'(bus.tx_data), 32'h41);
        peek_stat("tp1.status", 32'h0000_0300);

        // Drain
        for (int i = 0; i < 3; i++) cyc(12'h000, 32'h0, 1'b0, 1'b1);
        chk("tp2.tx_valid", 32'(bus.tx_valid), 32'h0);
        peek_stat("tp2.status", 32'h0000_0001);

        // Overfill by one, then clear the sticky flag
        for (int i = 0; i < 9; i++) cyc(12'hFFF, 32'h0000_0060 + 32'(i), 1'b1, 1'b0);
        peek_stat("tp3.status", 32'h0000_0806);
        chk("tp3.overflow", 32'(bus.overflow), 32'(STAT_EN));
        cyc(12'hFFE, 32'h0000_0001, 1'b1, 1'b0);
        chk("tp3.ovf_clr", 32'(bus.overflow), 32'h0);
        peek_stat("tp3.status_clr", 32'h0000_0802);

        // Full with simultaneous pop and push
        cyc(12'hFFF, 32'h0000_0055, 1'b1, 1'b1);
        peek_stat("tp4.status", 32'h0000_0802);
        chk("tp4.overflow", 32'(bus.overflow), 32'h0);
        for (int i = 0; i < 8; i++) cyc(12'h000, 32'h0, 1'b0, 1'b1);
        chk("tp4.empty", 32'(bus.tx_valid), 32'h0);

        // Pass-through store and read
        bus.address_dmem = 12'h010;
        bus.data         = 32'hDEAD_BEEF;
        bus.wren         = 1'b1;
        bus.q_dmem       = 32'h1234_5678;
        #1;
        chk("tp5.dmem_wren", 32'(bus.dmem_wren), 32'h1);
        @(negedge clock);
        cyc(12'h010, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset with entries queued
        for (int i = 0; i < 4; i++) cyc(12'hFFF, 32'h0000_0070 + 32'(i), 1'b1, 1'b0);
        chk("tp6.pre_valid", 32'(bus.tx_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("tp6.async_valid", 32'(bus.tx_valid), 32'h0);
        mq.delete();
        movf = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        peek_stat("tp6.status", 32'h0000_0001);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [11:0] a;
            int sel;
            sel = $urandom_range(0, 3);
            a = (sel == 0) ? 12'hFFF : (sel == 1) ? 12'hFFE : 12'($urandom);
            cyc(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
